mac_rst_seq: RTL and testbench
==============================

MAC_RST_SEQ -- requirements
Module: mac_rst_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, sets the number of cycles sys_rst is held high per violation; legal range 1..255.
REQ-002 Parameter GUARD_CYCLES, default 2, sets the post-reset blanking cycles during which viol is ignored; legal range 0..15.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 viol  input  1  level violation request from the memory access controller; active high.
REQ-006 pc  input  16  current program counter.
REQ-007 data_en  input  1  data-bus access strobe.
REQ-008 data_addr  input  16  data-bus address.
REQ-009 code_en  input  1  code-bus access strobe.
REQ-010 code_addr  input  16  code-bus address.
REQ-011 clr  input  1  single-cycle pulse that clears the violation log.
REQ-012 sys_rst  output  1  registered system reset request; active high.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 viol_cnt  output  8  saturating count of accepted violations.
REQ-015 viol_pc  output  16  pc captured at the last accepted violation.
REQ-016 viol_addr  output  16  access address captured at the last accepted violation.
REQ-017 viol_kind  output  2  access type captured at the last accepted violation.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, HOLD and GUARD.
REQ-019 In IDLE, a cycle with viol=1 is an accepted violation; the next state SHALL be HOLD, with the hold timer loaded to HOLD_CYCLES-1.
REQ-020 On acceptance, viol_pc <= pc, and viol_addr <= data_addr if data_en=1, else code_addr if code_en=1, else 16'h0000.
REQ-021 On acceptance, viol_kind <= {code_en, data_en}: 01 = data, 10 = code, 11 = both, 00 = pc-only.
REQ-022 On acceptance, viol_cnt SHALL increment by 1 and saturate at 8'hFF (no wrap).
REQ-023 sys_rst SHALL be high in HOLD only; it first rises at the clock edge after the accepting edge (latency 1).
REQ-024 sys_rst SHALL stay high for exactly HOLD_CYCLES consecutive cycles.
REQ-025 In HOLD, the timer decrements each cycle; when timer=0, the next state SHALL be GUARD if GUARD_CYCLES>0, else IDLE.
REQ-026 In GUARD, sys_rst=0 and a guard timer counts GUARD_CYCLES cycles, then the next state SHALL be IDLE.
REQ-027 viol SHALL be ignored in HOLD and GUARD: no capture, no count, no timer reload.
REQ-028 A violation asserted on the first cycle back in IDLE SHALL be accepted normally (back-to-back sequences allowed).
REQ-029 clr=1 SHALL zero viol_cnt, viol_pc, viol_addr and viol_kind in any state, without affecting the FSM or sys_rst.
REQ-030 clr and an accepted violation in the same cycle: the capture wins; viol_cnt becomes 1 and the captured fields hold the new values.
REQ-031 The captured fields SHALL be stable outside acceptance and clear cycles.
REQ-032 busy SHALL be a registered decode of state != IDLE and rise in the same cycle as sys_rst.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE, sys_rst=0, busy=0, all timers 0, viol_cnt=0, viol_pc=0, viol_addr=0 and viol_kind=0.
REQ-034 reset_n asserted mid-HOLD SHALL drop sys_rst immediately; after release the block starts in IDLE with no pending violation.
REQ-035 The first edge after reset_n deasserts SHALL be able to accept a violation.

Verification
REQ-036 Defaults: viol pulse 1 cycle, pc=A010, data_en=1, data_addr=0600 -> sys_rst high cycles 1..16, GUARD 2 cycles, viol_cnt=1, viol_addr=0600, viol_kind=01.
REQ-037 viol held high for 30 cycles, defaults -> exactly two accepted violations (cycle 0 and the first IDLE cycle, cycle 19), viol_cnt=2.
REQ-038 code_en=1, code_addr=A3FE, data_en=0, viol pulse -> viol_addr=A3FE, viol_kind=10; with both enables high -> viol_addr=data_addr, viol_kind=11.
REQ-039 Force viol_cnt to 255 via 255 sequences, then one more -> viol_cnt stays FF; clr together with viol -> viol_cnt=01.
REQ-040 reset_n pulled low at HOLD cycle 5 -> sys_rst=0 asynchronously, all logs 0; HOLD_CYCLES=1, GUARD_CYCLES=0 -> sys_rst exactly one cycle, then IDLE.

Source files
------------

// File: rtl/mac_rst_seq_if.sv
// mac_rst_seq_if: violation request, access context and reset/log outputs of mac_rst_seq
interface mac_rst_seq_if;
    logic        viol;
    logic [15:0] pc;
    logic        data_en;
    logic [15:0] data_addr;
    logic        code_en;
    logic [15:0] code_addr;
    logic        clr;
    logic        sys_rst;
    logic        busy;
    logic [7:0]  viol_cnt;
    logic [15:0] viol_pc;
    logic [15:0] viol_addr;
    logic [1:0]  viol_kind;
    modport master (
        output viol, pc, data_en, data_addr, code_en, code_addr, clr,
        input  sys_rst, busy, viol_cnt, viol_pc, viol_addr, viol_kind
    );
    modport slave (
        input  viol, pc, data_en, data_addr, code_en, code_addr, clr,
        output sys_rst, busy, viol_cnt, viol_pc, viol_addr, viol_kind
    );
endinterface

// File: rtl/mac_rst_seq.sv
// mac_rst_seq: turns memory-access violations into a timed system reset and logs the offending access
module mac_rst_seq #(
    parameter int HOLD_CYCLES  = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    mac_rst_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, GUARD} state_t;
    state_t     state;
    logic [7:0] timer;
    // FSM, hold/guard timer and violation log; a capture overrides a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= 8'd0;
            bus.sys_rst   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.viol_cnt  <= 8'd0;
            bus.viol_pc   <= 16'h0000;
            bus.viol_addr <= 16'h0000;
            bus.viol_kind <= 2'b00;
        end else begin
            if (bus.clr) begin
                bus.viol_cnt  <= 8'd0;
                bus.viol_pc   <= 16'h0000;
                bus.viol_addr <= 16'h0000;
                bus.viol_kind <= 2'b00;
            end
            case (state)
                IDLE: if (bus.viol) begin
                    state         <= HOLD;
                    timer         <= 8'(HOLD_CYCLES - 1);
                    bus.sys_rst   <= 1'b1;
                    bus.busy      <= 1'b1;
                    bus.viol_pc   <= bus.pc;
                    bus.viol_addr <= bus.data_en ? bus.data_addr : bus.code_en ? bus.code_addr : 16'h0000;
                    bus.viol_kind <= {bus.code_en, bus.data_en};
                    bus.viol_cnt  <= bus.clr ? 8'd1 : bus.viol_cnt == 8'hFF ? 8'hFF : bus.viol_cnt + 8'd1;
                end
                HOLD: if (timer == 8'd0) begin
                    bus.sys_rst <= 1'b0;
                    if (GUARD_CYCLES > 0) begin
                        state <= GUARD;
                        timer <= 8'(GUARD_CYCLES - 1);
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end else begin
                    timer <= timer - 8'd1;
                end
                GUARD: if (timer == 8'd0) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end else begin
                    timer <= timer - 8'd1;
                end
                default: begin
                    state       <= IDLE;
                    timer       <= 8'd0;
                    bus.sys_rst <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_rst_seq.sv
// tb_mac_rst_seq: directed vector table plus hand sequences for timing, saturation, clear and reset corners
module tb_mac_rst_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    mac_rst_seq_if b ();
    mac_rst_seq_if b2 ();
    mac_rst_seq u_dut (.clk(clk), .reset_n(reset_n), .bus(b.slave));
    mac_rst_seq #(.HOLD_CYCLES(1), .GUARD_CYCLES(0)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] pc;
        logic        de;
        logic [15:0] da;
        logic        ce;
        logic [15:0] ca;
        logic        cl;
        logic [7:0]  ecnt;
        logic [15:0] eaddr;
        logic [1:0]  ekind;
    } vec_t;
    vec_t v[5];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic wait_idle();
        int n = 0;
        while (b.busy && n < 300) begin
            n++;
            cyc();
        end
        chk("wait_idle_timeout", 32'(n < 300), 32'd1);
    endtask
    // called at a negedge: one-cycle viol pulse, then measures sys_rst and guard lengths
    task automatic pulse(input logic [15:0] pc, input logic de, input logic [15:0] da,
                         input logic ce, input logic [15:0] ca, input logic cl,
                         output int hc, output int gc);
        b.viol = 1'b1; b.pc = pc; b.data_en = de; b.data_addr = da;
        b.code_en = ce; b.code_addr = ca; b.clr = cl;
        cyc();
        b.viol = 1'b0; b.clr = 1'b0;
        hc = 0;
        while (b.sys_rst && hc < 300) begin
            hc++;
            cyc();
        end
        gc = 0;
        while (b.busy && gc < 300) begin
            gc++;
            cyc();
        end
    endtask
    initial begin
        int hc, gc, r1, r2, nr;
        logic prev;
        v[0] = '{16'hA010, 1'b1, 16'h0600, 1'b0, 16'h1234, 1'b0, 8'd1, 16'h0600, 2'b01};
        v[1] = '{16'h0042, 1'b0, 16'h0777, 1'b1, 16'hA3FE, 1'b0, 8'd2, 16'hA3FE, 2'b10};
        v[2] = '{16'h1111, 1'b1, 16'h0B00, 1'b1, 16'hC000, 1'b0, 8'd3, 16'h0B00, 2'b11};
        v[3] = '{16'hFFFE, 1'b0, 16'h5555, 1'b0, 16'h6666, 1'b0, 8'd4, 16'h0000, 2'b00};
        v[4] = '{16'h2222, 1'b1, 16'h0010, 1'b0, 16'h9999, 1'b1, 8'd1, 16'h0010, 2'b01};
        b.viol = 1'b0; b.pc = '0; b.data_en = 1'b0; b.data_addr = '0;
        b.code_en = 1'b0; b.code_addr = '0; b.clr = 1'b0;
        b2.viol = 1'b0; b2.pc = '0; b2.data_en = 1'b0; b2.data_addr = '0;
        b2.code_en = 1'b0; b2.code_addr = '0; b2.clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sys_rst", 32'(b.sys_rst), 32'd0);
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_cnt", 32'(b.viol_cnt), 32'd0);
        chk("rst_pc", 32'(b.viol_pc), 32'd0);
        chk("rst_addr", 32'(b.viol_addr), 32'd0);
        chk("rst_kind", 32'(b.viol_kind), 32'd0);
        chk("rst_sys_rst2", 32'(b2.sys_rst), 32'd0);
        reset_n = 1'b1;
        // first vector goes in on the very first edge after release
        for (int i = 0; i < 5; i++) begin
            pulse(v[i].pc, v[i].de, v[i].da, v[i].ce, v[i].ca, v[i].cl, hc, gc);
            chk($sformatf("vec%0d_cnt", i), 32'(b.viol_cnt), 32'(v[i].ecnt));
            chk($sformatf("vec%0d_pc", i), 32'(b.viol_pc), 32'(v[i].pc));
            chk($sformatf("vec%0d_addr", i), 32'(b.viol_addr), 32'(v[i].eaddr));
            chk($sformatf("vec%0d_kind", i), 32'(b.viol_kind), 32'(v[i].ekind));
            chk($sformatf("vec%0d_hold", i), 32'(hc), 32'd16);
            chk($sformatf("vec%0d_guard", i), 32'(gc), 32'd2);
        end
        b.clr = 1'b1;
        cyc();
        b.clr = 1'b0;
        chk("clr_idle_cnt", 32'(b.viol_cnt), 32'd0);
        chk("clr_idle_pc", 32'(b.viol_pc), 32'd0);
        chk("clr_idle_addr", 32'(b.viol_addr), 32'd0);
        chk("clr_idle_kind", 32'(b.viol_kind), 32'd0);
        chk("clr_idle_busy", 32'(b.busy), 32'd0);
        b.viol = 1'b1; b.pc = 16'hA010; b.data_en = 1'b1; b.data_addr = 16'h0600; b.code_en = 1'b0;
        cyc();
        b.viol = 1'b0;
        chk("lat_sys_rst", 32'(b.sys_rst), 32'd1);
        chk("lat_busy", 32'(b.busy), 32'd1);
        repeat (3) cyc();
        b.viol = 1'b1; b.pc = 16'h7777;
        cyc();
        b.viol = 1'b0;
        chk("hold_ignore_pc", 32'(b.viol_pc), 32'hA010);
        chk("hold_ignore_cnt", 32'(b.viol_cnt), 32'd1);
        b.clr = 1'b1;
        cyc();
        b.clr = 1'b0;
        chk("clr_hold_sys_rst", 32'(b.sys_rst), 32'd1);
        chk("clr_hold_busy", 32'(b.busy), 32'd1);
        chk("clr_hold_cnt", 32'(b.viol_cnt), 32'd0);
        chk("clr_hold_pc", 32'(b.viol_pc), 32'd0);
        wait_idle();
        b.pc = 16'hA010;
        b.viol = 1'b1;
        prev = b.sys_rst; r1 = -1; r2 = -1; nr = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (b.sys_rst && !prev) begin
                nr++;
                if (nr == 1) r1 = i;
                if (nr == 2) r2 = i;
            end
            prev = b.sys_rst;
        end
        b.viol = 1'b0;
        wait_idle();
        chk("held_rise1", 32'(r1), 32'd1);
        chk("held_rise2", 32'(r2), 32'd20);
        chk("held_rises", 32'(nr), 32'd2);
        chk("held_cnt", 32'(b.viol_cnt), 32'd2);
        b.clr = 1'b1;
        cyc();
        b.clr = 1'b0;
        for (int i = 0; i < 255; i++) pulse(16'h0100, 1'b1, 16'h0200, 1'b0, 16'h0, 1'b0, hc, gc);
        chk("sat_255", 32'(b.viol_cnt), 32'hFF);
        pulse(16'h0101, 1'b1, 16'h0201, 1'b0, 16'h0, 1'b0, hc, gc);
        chk("sat_stay", 32'(b.viol_cnt), 32'hFF);
        chk("sat_pc", 32'(b.viol_pc), 32'h0101);
        pulse(16'h0102, 1'b0, 16'h0, 1'b1, 16'h0302, 1'b1, hc, gc);
        chk("sat_clr_cnt", 32'(b.viol_cnt), 32'd1);
        chk("sat_clr_addr", 32'(b.viol_addr), 32'h0302);
        b.viol = 1'b1; b.pc = 16'hA010; b.data_en = 1'b1; b.data_addr = 16'h0600; b.code_en = 1'b0;
        cyc();
        b.viol = 1'b0;
        repeat (4) cyc();
        chk("mid_hold_sys_rst", 32'(b.sys_rst), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_sys_rst", 32'(b.sys_rst), 32'd0);
        chk("async_busy", 32'(b.busy), 32'd0);
        chk("async_cnt", 32'(b.viol_cnt), 32'd0);
        chk("async_pc", 32'(b.viol_pc), 32'd0);
        chk("async_addr", 32'(b.viol_addr), 32'd0);
        chk("async_kind", 32'(b.viol_kind), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("post_rst_busy", 32'(b.busy), 32'd0);
        chk("post_rst_sys_rst", 32'(b.sys_rst), 32'd0);
        b2.viol = 1'b1; b2.pc = 16'h1234; b2.data_en = 1'b1; b2.data_addr = 16'h0ABC;
        cyc();
        b2.viol = 1'b0;
        chk("h1_sys_rst_on", 32'(b2.sys_rst), 32'd1);
        chk("h1_busy_on", 32'(b2.busy), 32'd1);
        chk("h1_cnt", 32'(b2.viol_cnt), 32'd1);
        cyc();
        chk("h1_sys_rst_off", 32'(b2.sys_rst), 32'd0);
        chk("h1_busy_off", 32'(b2.busy), 32'd0);
        b2.viol = 1'b1;
        cyc();
        b2.viol = 1'b0;
        chk("h1_b2b_sys_rst", 32'(b2.sys_rst), 32'd1);
        chk("h1_b2b_cnt", 32'(b2.viol_cnt), 32'd2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
